uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-004 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, >= 2).
REQ-007 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1, meaning synchronous, active-low reset.
REQ-009 SHALL have port rx, input, 1, meaning asynchronous serial line (idle high).
REQ-010 SHALL have port data_out, output, DATA_WIDTH, meaning head-of-FIFO payload.
REQ-011 SHALL have port valid, output, 1, meaning FIFO non-empty; data_out/parity_err/frame_err valid.
REQ-012 SHALL have port ready, input, 1, meaning consumer pops head when valid && ready.
REQ-013 SHALL have port parity_err, output, 1, meaning head entry failed parity (always 0 when PARITY_MODE=0).
REQ-014 SHALL have port frame_err, output, 1, meaning head entry had a low stop-bit sample.
REQ-015 SHALL have port overrun, output, 1, meaning one-cycle pulse when a completed frame was dropped.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning current occupancy.

Function
REQ-017 SHALL define CYCLES_PER_BIT = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE and MID = CYCLES_PER_BIT/2; CYCLES_PER_BIT < 8 is an elaboration error.
REQ-018 SHALL pass rx through a 2-flop synchroniser; all logic uses the synchronised value.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START on synchronised rx low; the bit cycle counter clears on entry.
REQ-021 Each bit value SHALL be the majority of samples at counter MID-1, MID, MID+1.
REQ-022 START: majority 1 -> IDLE (false start, nothing pushed); majority 0 -> DATA at counter CYCLES_PER_BIT-1.
REQ-023 DATA SHALL capture DATA_WIDTH bits LSB-first, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-024 parity_err SHALL be set when (XOR of data and parity bit) != 0 for even, or == 0 for odd.
REQ-025 STOP SHALL sample STOP_BITS bits; frame_err = any stop majority 0.
REQ-026 The frame SHALL complete one cycle after the last stop bit's MID+1 sample: push {frame_err, parity_err, data}, then go to IDLE.
REQ-027 The FIFO SHALL be first-word-fall-through: a push into an empty FIFO raises valid the following cycle.
REQ-028 A push with the FIFO full and no pop the same cycle SHALL drop the frame and pulse overrun; stored contents SHALL be unchanged.
REQ-029 A simultaneous push and pop when full SHALL be accepted; fifo_count is unchanged.
REQ-030 A pop when empty SHALL be ignored; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 On rst_n low: FSM IDLE, counters 0, synchroniser flops 1, FIFO empty, valid/overrun/data_out/parity_err/frame_err 0, fifo_count 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; no push occurs after reset release until a new start bit.

Structure
REQ-033 The FSM state enum and PARITY_MODE encodings SHALL reside in shared package uart_pkg.
REQ-034 FIFO storage SHALL be sub-module uart_sync_fifo, parameterised by width and depth, with a valid/ready read side.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=62_500, CYCLES_PER_BIT=16)
REQ-035 PARITY_MODE=0: send 0xA5, 1 stop bit -> data_out=0xA5, valid=1, both errors 0; valid rises 2 cycles after the stop-bit MID+1 sample.
REQ-036 PARITY_MODE=1: send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-037 Stop bit driven 0 with data 0x00 -> frame_err=1, data_out=0x00, FSM returns to IDLE.
REQ-038 ready=0, send 9 bytes 0x01..0x09 -> fifo_count=8, a single overrun pulse on the 9th frame; draining yields 0x01..0x08 in order.
REQ-039 rx low for 4 cycles, then high -> no push; a one-cycle low glitch at a data bit's MID is rejected by the majority vote.
REQ-040 rst_n asserted during the 5th data bit of a frame -> FIFO empty and no valid; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity mode encodings and small bit-level helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // data_xor is the XOR-reduction of the payload, pbit the received parity bit
    function automatic logic parity_bad(input logic data_xor, input logic pbit, input int mode);
        return (mode == PARITY_ODD) ? ~(data_xor ^ pbit) : (data_xor ^ pbit);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with a registered head. Pushes into a full FIFO
// without a simultaneous pop are dropped and flagged on the following cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     drop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             drop_reg;
    logic             pop;
    logic             wr_en;

    assign valid       = (count_reg != '0);
    assign pop         = valid && ready;
    assign wr_en       = push && ((count_reg != FULL_COUNT) || pop);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            drop_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(wr_en);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
            drop_reg   <= push && !wr_en;
            // The written word becomes the new head when nothing else remains ahead of it
            if (wr_en && (count_reg == (AW+1)'(pop))) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign head  = head_reg;
    assign drop  = drop_reg;
    assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting per bit, optional parity and
// 1 or 2 checked stop bits, feeding a FWFT receive FIFO with overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLES_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int MID            = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MID + 2);
    localparam logic [3:0] IDX_DATA_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] IDX_STOP_LAST  = 4'(STOP_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 8) begin : g_baud_check
            $error("uart_rx_fifo: CYCLES_PER_BIT must be at least 8");
        end
    endgenerate

    logic                  rx_meta_reg;
    logic                  rx_sync_reg;
    rx_state_t             state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [2:0]            samples_reg;
    logic [3:0]            idx_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_err_reg;
    logic                  frame_err_reg;
    logic                  push_reg;
    logic                  bit_val;

    assign bit_val = majority3(samples_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            samples_reg    <= '0;
            idx_reg        <= '0;
            shift_reg      <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            push_reg       <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            push_reg    <= 1'b0;
            if (state_reg != ST_IDLE && cnt_reg >= CNT_LO && cnt_reg <= CNT_HI) begin
                samples_reg <= {samples_reg[1:0], rx_sync_reg};
            end
            if (state_reg != ST_IDLE) begin
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_sync_reg) begin
                        state_reg      <= ST_START;
                        cnt_reg        <= '0;
                        idx_reg        <= '0;
                        parity_err_reg <= 1'b0;
                        frame_err_reg  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= bit_val ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        if (idx_reg == IDX_DATA_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt_reg == CNT_LAST) begin
                        parity_err_reg <= parity_bad(^shift_reg, bit_val, PARITY_MODE);
                        state_reg      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // The last stop bit ends early so the receiver can resync on a back-to-back start
                    if (idx_reg == IDX_STOP_LAST && cnt_reg == CNT_DONE) begin
                        frame_err_reg <= frame_err_reg | ~bit_val;
                        push_reg      <= 1'b1;
                        state_reg     <= ST_IDLE;
                        cnt_reg       <= '0;
                        idx_reg       <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        frame_err_reg <= frame_err_reg | ~bit_val;
                        idx_reg       <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_reg),
        .push_data ({frame_err_reg, parity_err_reg, shift_reg}),
        .drop      (overrun),
        .head      ({frame_err, parity_err, data_out}),
        .valid     (valid),
        .ready     (ready),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: dut0 has no parity, dut1 even parity; stimulus pushes
// expected {frame_err, parity_err, data} words, monitors pop and compare.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       ready0 = 1'b1;
    logic       ready1 = 1'b1;
    logic [7:0] data_out0, data_out1;
    logic       valid0, valid1;
    logic       parity_err0, parity_err1;
    logic       frame_err0, frame_err1;
    logic       overrun0, overrun1;
    logic [3:0] fifo_count0, fifo_count1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr0 = 0;
    int ovr1 = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo #(
        .DATA_WIDTH(8), .CLOCK_FREQ(1_000_000), .BAUD_RATE(62_500),
        .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data_out(data_out0), .valid(valid0),
        .ready(ready0), .parity_err(parity_err0), .frame_err(frame_err0),
        .overrun(overrun0), .fifo_count(fifo_count0)
    );

    uart_rx_fifo #(
        .DATA_WIDTH(8), .CLOCK_FREQ(1_000_000), .BAUD_RATE(62_500),
        .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data_out(data_out1), .valid(valid1),
        .ready(ready1), .parity_err(parity_err1), .frame_err(frame_err1),
        .overrun(overrun1), .fifo_count(fifo_count1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    // pbit < 0 means no parity bit; glitch >= 0 inverts that data bit for one cycle at its centre
    task automatic send_frame(input int which, input logic [7:0] d, input int pbit,
                              input logic stop, input int glitch);
        drive(which, 1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                drive(which, d[i], 9);
                drive(which, ~d[i], 1);
                drive(which, d[i], 6);
            end else begin
                drive(which, d[i], CPB);
            end
        end
        if (pbit >= 0) drive(which, pbit[0], CPB);
        drive(which, stop, CPB);
        drive(which, 1'b1, 0);
    endtask

    // Monitors: one line per popped frame, compared against the scoreboard queues
    initial begin
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (overrun0) ovr0++;
            if (overrun1) ovr1++;
            if (rst_n && valid0 && ready0) begin
                $display("rx0 pop data=%02h pe=%b fe=%b", data_out0, parity_err0, frame_err0);
                if (q0.size() == 0) check("rx0_unexpected", {frame_err0, parity_err0, data_out0}, -1);
                else begin
                    exp = q0.pop_front();
                    check("rx0_frame", {frame_err0, parity_err0, data_out0}, exp);
                end
            end
            if (rst_n && valid1 && ready1) begin
                $display("rx1 pop data=%02h pe=%b fe=%b", data_out1, parity_err1, frame_err1);
                if (q1.size() == 0) check("rx1_unexpected", {frame_err1, parity_err1, data_out1}, -1);
                else begin
                    exp = q1.pop_front();
                    check("rx1_frame", {frame_err1, parity_err1, data_out1}, exp);
                end
            end
        end
    end

    initial begin
        int t0;
        int o;
        bit got;
        logic [7:0] pd;

        repeat (3) @(negedge clk);
        check("rst_valid0", valid0, 0);
        check("rst_data0", data_out0, 0);
        check("rst_pe0", parity_err0, 0);
        check("rst_fe0", frame_err0, 0);
        check("rst_ovr0", overrun0, 0);
        check("rst_count0", fifo_count0, 0);
        check("rst_valid1", valid1, 0);
        check("rst_data1", data_out1, 0);
        check("rst_pe1", parity_err1, 0);
        check("rst_fe1", frame_err1, 0);
        check("rst_ovr1", overrun1, 0);
        check("rst_count1", fifo_count1, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame plus latency from start-bit edge to valid
        q0.push_back({2'b00, 8'hA5});
        fork
            send_frame(0, 8'hA5, -1, 1'b1, -1);
            begin
                t0 = cyc;
                got = 0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    #1;
                    if (valid0) begin
                        got = 1;
                        break;
                    end
                end
                check("valid_latency", got ? (cyc - t0) : -1, 159);
            end
        join

        // Single-cycle low glitch at the centre of a '1' data bit
        q0.push_back({2'b00, 8'hFF});
        send_frame(0, 8'hFF, -1, 1'b1, 3);
        q0.push_back({2'b00, 8'h3C});
        send_frame(0, 8'h3C, -1, 1'b1, -1);

        // False start: short low pulse must not produce a frame
        drive(0, 1'b1, 10);
        ready0 = 1'b0;
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 40);
        check("false_start_count", fifo_count0, 0);
        ready0 = 1'b1;
        q0.push_back({2'b00, 8'h96});
        send_frame(0, 8'h96, -1, 1'b1, -1);

        // Framing error, then a clean frame proves the FSM recovered
        q0.push_back({2'b10, 8'h00});
        send_frame(0, 8'h00, -1, 1'b0, -1);
        drive(0, 1'b1, 40);
        q0.push_back({2'b00, 8'h81});
        send_frame(0, 8'h81, -1, 1'b1, -1);

        // Even parity on dut1
        q1.push_back({2'b01, 8'h03});
        send_frame(1, 8'h03, 1, 1'b1, -1);
        q1.push_back({2'b00, 8'h03});
        send_frame(1, 8'h03, 0, 1'b1, -1);
        q1.push_back({2'b00, 8'hA5});
        send_frame(1, 8'hA5, 0, 1'b1, -1);
        q1.push_back({2'b01, 8'h07});
        send_frame(1, 8'h07, 0, 1'b1, -1);

        // Overrun: fill with ready low, the ninth frame is dropped
        drive(0, 1'b1, 20);
        ready0 = 1'b0;
        o = ovr0;
        for (int k = 1; k <= 9; k++) begin
            pd = 8'(k);
            if (k <= 8) q0.push_back({2'b00, pd});
            send_frame(0, pd, -1, 1'b1, -1);
            if (k == 8) begin
                check("count_at_8", fifo_count0, 8);
                check("ovr_before_9th", ovr0 - o, 0);
            end
        end
        drive(0, 1'b1, 5);
        check("count_full", fifo_count0, 8);
        check("ovr_pulses", ovr0 - o, 1);
        ready0 = 1'b1;
        drive(0, 1'b1, 20);
        check("count_drained", fifo_count0, 0);

        // Reset during the fifth data bit discards the partial frame
        pd = 8'hC3;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(0, pd[i], CPB);
        drive(0, pd[4], 8);
        rst_n = 1'b0;
        drive(0, 1'b1, 3);
        rst_n = 1'b1;
        drive(0, 1'b1, 40);
        check("rst_mid_valid", valid0, 0);
        check("rst_mid_count", fifo_count0, 0);
        q0.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, -1, 1'b1, -1);

        for (int i = 0; i < 2000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        check("ovr1_none", ovr1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
